// File: rtl/saturn_instr_decoder.sv
// Nibble-serial Saturn instruction decoder: RTN/SETHEX/SETDEC/RSTK/ST/P ops, P=n, LC and GOTO/GOSUB.
// Optional macro SATURN_DEC_JUMP_EN enables decoding of GOTO/GOSUB (first nibble 6/7).
module saturn_instr_decoder #(
  parameter int unsigned ADDR_W      = 20,
  parameter int unsigned IMM_NIBBLES = 16
) (
  input  logic                     i_clk,
  input  logic                     i_reset,
  input  logic                     i_en_dec,
  input  logic                     i_stalled,
  input  logic [ADDR_W-1:0]        i_pc,
  input  logic [3:0]               i_nibble,
  output logic                     o_inc_pc,
  output logic                     o_dec_error,
  output logic [ADDR_W-1:0]        o_ins_addr,
  output logic                     o_ins_decoded,
  output logic [4:0]               o_ins_len,
  output logic                     o_direction,
  output logic                     o_ins_rtn,
  output logic                     o_set_xm,
  output logic                     o_set_carry,
  output logic                     o_carry_val,
  output logic                     o_ins_set_mode,
  output logic                     o_mode_dec,
  output logic                     o_ins_rstk_c,
  output logic                     o_ins_st_op,
  output logic [1:0]               o_st_op,
  output logic                     o_ins_p_inc,
  output logic                     o_ins_p_set,
  output logic                     o_ins_lc,
  output logic [4*IMM_NIBBLES-1:0] o_imm,
  output logic [4:0]               o_imm_len,
  output logic                     o_ins_jmp,
  output logic                     o_jmp_call,
  output logic [ADDR_W-1:0]        o_jmp_addr
);

  localparam int unsigned IMM_W = 4 * IMM_NIBBLES;

  typedef enum logic [2:0] {
    S_FIRST, S_BLK_0X, S_P_N, S_LC_N, S_IMM, S_HALT
`ifdef SATURN_DEC_JUMP_EN
    , S_JMP
`endif
  } state_t;

  state_t            state, state_d;
  logic              accept, err;
  logic              inc_pc_d, dec_error_d, decoded_d, direction_d;
  logic              rtn_d, set_xm_d, set_carry_d, carry_val_d, set_mode_d, mode_dec_d;
  logic              rstk_c_d, st_op_v_d, p_inc_d, p_set_d, lc_d;
  logic [1:0]        st_op_d;
  logic [4:0]        ins_len_d, imm_len_d, imm_idx, imm_idx_d, lc_cnt;
  logic [ADDR_W-1:0] ins_addr_d;
  logic [IMM_W-1:0]  imm_d;
`ifdef SATURN_DEC_JUMP_EN
  logic              jmp_d, call_d;
  logic [1:0]        jmp_cnt, jmp_cnt_d;
  logic [7:0]        jmp_off, jmp_off_d;
  logic [ADDR_W-1:0] jmp_addr_d;
  logic signed [11:0] off_full;
`endif

  assign accept = i_en_dec && !i_stalled;
  assign lc_cnt = {1'b0, i_nibble} + 5'd1;
`ifdef SATURN_DEC_JUMP_EN
  assign off_full = signed'({i_nibble, jmp_off});
`endif

  // Next-state and next-output logic; every register holds unless a nibble is accepted.
  always_comb begin
    state_d     = state;
    err         = 1'b0;
    inc_pc_d    = o_inc_pc;
    dec_error_d = o_dec_error;
    ins_addr_d  = o_ins_addr;
    decoded_d   = o_ins_decoded;
    ins_len_d   = o_ins_len;
    direction_d = o_direction;
    rtn_d       = o_ins_rtn;
    set_xm_d    = o_set_xm;
    set_carry_d = o_set_carry;
    carry_val_d = o_carry_val;
    set_mode_d  = o_ins_set_mode;
    mode_dec_d  = o_mode_dec;
    rstk_c_d    = o_ins_rstk_c;
    st_op_v_d   = o_ins_st_op;
    st_op_d     = o_st_op;
    p_inc_d     = o_ins_p_inc;
    p_set_d     = o_ins_p_set;
    lc_d        = o_ins_lc;
    imm_d       = o_imm;
    imm_len_d   = o_imm_len;
    imm_idx_d   = imm_idx;
`ifdef SATURN_DEC_JUMP_EN
    jmp_d       = o_ins_jmp;
    call_d      = o_jmp_call;
    jmp_addr_d  = o_jmp_addr;
    jmp_cnt_d   = jmp_cnt;
    jmp_off_d   = jmp_off;
`endif
    if (accept) begin
      unique case (state)
        S_FIRST: begin
          ins_addr_d  = i_pc;
          decoded_d   = 1'b0;
          ins_len_d   = '0;
          direction_d = 1'b0;
          rtn_d       = 1'b0;
          set_xm_d    = 1'b0;
          set_carry_d = 1'b0;
          carry_val_d = 1'b0;
          set_mode_d  = 1'b0;
          mode_dec_d  = 1'b0;
          rstk_c_d    = 1'b0;
          st_op_v_d   = 1'b0;
          st_op_d     = '0;
          p_inc_d     = 1'b0;
          p_set_d     = 1'b0;
          lc_d        = 1'b0;
          imm_d       = '0;
          imm_len_d   = '0;
          imm_idx_d   = '0;
`ifdef SATURN_DEC_JUMP_EN
          jmp_d       = 1'b0;
          call_d      = 1'b0;
          jmp_addr_d  = '0;
          jmp_cnt_d   = '0;
          jmp_off_d   = '0;
`endif
          case (i_nibble)
            4'h0: state_d = S_BLK_0X;
            4'h2: state_d = S_P_N;
            4'h3: state_d = S_LC_N;
`ifdef SATURN_DEC_JUMP_EN
            4'h6, 4'h7: begin
              state_d = S_JMP;
              jmp_d   = 1'b1;
              call_d  = i_nibble[0];
            end
`endif
            default: err = 1'b1;
          endcase
        end
        S_BLK_0X: begin
          state_d   = S_FIRST;
          decoded_d = 1'b1;
          ins_len_d = 5'd2;
          case (i_nibble)
            4'h0, 4'h1, 4'h2, 4'h3: begin
              rtn_d       = 1'b1;
              set_xm_d    = (i_nibble == 4'h0);
              set_carry_d = i_nibble[1];
              carry_val_d = (i_nibble == 4'h3);
            end
            4'h4, 4'h5: begin
              set_mode_d = 1'b1;
              mode_dec_d = i_nibble[0];
            end
            4'h6, 4'h7: begin
              rstk_c_d    = 1'b1;
              direction_d = i_nibble[0];
            end
            4'h8, 4'h9, 4'hA, 4'hB: begin
              st_op_v_d = 1'b1;
              st_op_d   = i_nibble[1:0];
            end
            4'hC, 4'hD: begin
              p_inc_d     = 1'b1;
              direction_d = i_nibble[0];
            end
            default: begin
              err       = 1'b1;
              decoded_d = 1'b0;
              ins_len_d = '0;
            end
          endcase
        end
        S_P_N: begin
          state_d     = S_FIRST;
          p_set_d     = 1'b1;
          imm_d[3:0]  = i_nibble;
          imm_len_d   = 5'd1;
          decoded_d   = 1'b1;
          ins_len_d   = 5'd2;
        end
        S_LC_N: begin
          if (lc_cnt > 5'(IMM_NIBBLES)) begin
            err = 1'b1;
          end else begin
            state_d   = S_IMM;
            lc_d      = 1'b1;
            imm_len_d = lc_cnt;
          end
        end
        S_IMM: begin
          for (int unsigned i = 0; i < IMM_NIBBLES; i++) begin
            if (imm_idx == 5'(i)) imm_d[4*i +: 4] = i_nibble;
          end
          imm_idx_d = imm_idx + 5'd1;
          if (imm_idx + 5'd1 == o_imm_len) begin
            state_d   = S_FIRST;
            decoded_d = 1'b1;
            ins_len_d = o_imm_len + 5'd2;
          end
        end
`ifdef SATURN_DEC_JUMP_EN
        // Offset is relative to the address following the opcode nibble.
        S_JMP: begin
          jmp_cnt_d = jmp_cnt + 2'd1;
          case (jmp_cnt)
            2'd0:    jmp_off_d[3:0] = i_nibble;
            2'd1:    jmp_off_d[7:4] = i_nibble;
            default: begin
              state_d    = S_FIRST;
              jmp_addr_d = o_ins_addr + ADDR_W'(1) + ADDR_W'(off_full);
              decoded_d  = 1'b1;
              ins_len_d  = 5'd4;
            end
          endcase
        end
`endif
        S_HALT: ;
        default: state_d = S_FIRST;
      endcase
    end
    if (err) begin
      state_d     = S_HALT;
      dec_error_d = 1'b1;
      inc_pc_d    = 1'b0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state          <= S_FIRST;
      o_inc_pc       <= 1'b1;
      o_dec_error    <= 1'b0;
      o_ins_addr     <= '0;
      o_ins_decoded  <= 1'b0;
      o_ins_len      <= '0;
      o_direction    <= 1'b0;
      o_ins_rtn      <= 1'b0;
      o_set_xm       <= 1'b0;
      o_set_carry    <= 1'b0;
      o_carry_val    <= 1'b0;
      o_ins_set_mode <= 1'b0;
      o_mode_dec     <= 1'b0;
      o_ins_rstk_c   <= 1'b0;
      o_ins_st_op    <= 1'b0;
      o_st_op        <= '0;
      o_ins_p_inc    <= 1'b0;
      o_ins_p_set    <= 1'b0;
      o_ins_lc       <= 1'b0;
      o_imm          <= '0;
      o_imm_len      <= '0;
      imm_idx        <= '0;
    end else begin
      state          <= state_d;
      o_inc_pc       <= inc_pc_d;
      o_dec_error    <= dec_error_d;
      o_ins_addr     <= ins_addr_d;
      o_ins_decoded  <= decoded_d;
      o_ins_len      <= ins_len_d;
      o_direction    <= direction_d;
      o_ins_rtn      <= rtn_d;
      o_set_xm       <= set_xm_d;
      o_set_carry    <= set_carry_d;
      o_carry_val    <= carry_val_d;
      o_ins_set_mode <= set_mode_d;
      o_mode_dec     <= mode_dec_d;
      o_ins_rstk_c   <= rstk_c_d;
      o_ins_st_op    <= st_op_v_d;
      o_st_op        <= st_op_d;
      o_ins_p_inc    <= p_inc_d;
      o_ins_p_set    <= p_set_d;
      o_ins_lc       <= lc_d;
      o_imm          <= imm_d;
      o_imm_len      <= imm_len_d;
      imm_idx        <= imm_idx_d;
    end
  end

`ifdef SATURN_DEC_JUMP_EN
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      o_ins_jmp  <= 1'b0;
      o_jmp_call <= 1'b0;
      o_jmp_addr <= '0;
      jmp_cnt    <= '0;
      jmp_off    <= '0;
    end else begin
      o_ins_jmp  <= jmp_d;
      o_jmp_call <= call_d;
      o_jmp_addr <= jmp_addr_d;
      jmp_cnt    <= jmp_cnt_d;
      jmp_off    <= jmp_off_d;
    end
  end
`else
  assign o_ins_jmp  = 1'b0;
  assign o_jmp_call = 1'b0;
  assign o_jmp_addr = '0;
`endif

endmodule

// File: tb/tb_saturn_instr_decoder.sv
// Scoreboard bench for saturn_instr_decoder; a second instance with IMM_NIBBLES=4 covers LC overflow.
module tb_saturn_instr_decoder;

  typedef struct packed {
    logic rtn, set_xm, set_carry, carry_val, set_mode, mode_dec, rstk_c, direction, st_v;
    logic [1:0] st_op;
    logic p_inc, p_set, lc, jmp, call;
  } flags_t;

  typedef struct {
    flags_t      f;
    logic [4:0]  ins_len;
    logic [63:0] imm;
    logic [4:0]  imm_len;
    logic [19:0] addr;
    logic [19:0] jaddr;
    int          done_cyc;
  } exp_t;

  logic        i_clk = 1'b0, i_reset = 1'b1, i_en_dec = 1'b0, i_stalled = 1'b0;
  logic [19:0] i_pc = '0;
  logic [3:0]  i_nibble = '0;

  logic        o_inc_pc, o_dec_error, o_ins_decoded, o_direction, o_ins_rtn, o_set_xm;
  logic        o_set_carry, o_carry_val, o_ins_set_mode, o_mode_dec, o_ins_rstk_c, o_ins_st_op;
  logic        o_ins_p_inc, o_ins_p_set, o_ins_lc, o_ins_jmp, o_jmp_call;
  logic [1:0]  o_st_op;
  logic [4:0]  o_ins_len, o_imm_len;
  logic [19:0] o_ins_addr, o_jmp_addr;
  logic [63:0] o_imm;

  logic        d4_inc_pc, d4_dec_error, d4_ins_decoded, d4_direction, d4_ins_rtn, d4_set_xm;
  logic        d4_set_carry, d4_carry_val, d4_ins_set_mode, d4_mode_dec, d4_ins_rstk_c, d4_ins_st_op;
  logic        d4_ins_p_inc, d4_ins_p_set, d4_ins_lc, d4_ins_jmp, d4_jmp_call;
  logic [1:0]  d4_st_op;
  logic [4:0]  d4_ins_len, d4_imm_len;
  logic [19:0] d4_ins_addr, d4_jmp_addr;
  logic [15:0] d4_imm;

  int   n_checks = 0, n_err = 0, cyc = 0;
  exp_t sb[$];
  logic prev_dec = 1'b0;
  flags_t act_f;

  saturn_instr_decoder #(.ADDR_W(20), .IMM_NIBBLES(16)) dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_en_dec(i_en_dec), .i_stalled(i_stalled),
    .i_pc(i_pc), .i_nibble(i_nibble), .o_inc_pc(o_inc_pc), .o_dec_error(o_dec_error),
    .o_ins_addr(o_ins_addr), .o_ins_decoded(o_ins_decoded), .o_ins_len(o_ins_len),
    .o_direction(o_direction), .o_ins_rtn(o_ins_rtn), .o_set_xm(o_set_xm),
    .o_set_carry(o_set_carry), .o_carry_val(o_carry_val), .o_ins_set_mode(o_ins_set_mode),
    .o_mode_dec(o_mode_dec), .o_ins_rstk_c(o_ins_rstk_c), .o_ins_st_op(o_ins_st_op),
    .o_st_op(o_st_op), .o_ins_p_inc(o_ins_p_inc), .o_ins_p_set(o_ins_p_set),
    .o_ins_lc(o_ins_lc), .o_imm(o_imm), .o_imm_len(o_imm_len), .o_ins_jmp(o_ins_jmp),
    .o_jmp_call(o_jmp_call), .o_jmp_addr(o_jmp_addr));

  saturn_instr_decoder #(.ADDR_W(20), .IMM_NIBBLES(4)) dut4 (
    .i_clk(i_clk), .i_reset(i_reset), .i_en_dec(i_en_dec), .i_stalled(i_stalled),
    .i_pc(i_pc), .i_nibble(i_nibble), .o_inc_pc(d4_inc_pc), .o_dec_error(d4_dec_error),
    .o_ins_addr(d4_ins_addr), .o_ins_decoded(d4_ins_decoded), .o_ins_len(d4_ins_len),
    .o_direction(d4_direction), .o_ins_rtn(d4_ins_rtn), .o_set_xm(d4_set_xm),
    .o_set_carry(d4_set_carry), .o_carry_val(d4_carry_val), .o_ins_set_mode(d4_ins_set_mode),
    .o_mode_dec(d4_mode_dec), .o_ins_rstk_c(d4_ins_rstk_c), .o_ins_st_op(d4_ins_st_op),
    .o_st_op(d4_st_op), .o_ins_p_inc(d4_ins_p_inc), .o_ins_p_set(d4_ins_p_set),
    .o_ins_lc(d4_ins_lc), .o_imm(d4_imm), .o_imm_len(d4_imm_len), .o_ins_jmp(d4_ins_jmp),
    .o_jmp_call(d4_jmp_call), .o_jmp_addr(d4_jmp_addr));

  assign act_f = {o_ins_rtn, o_set_xm, o_set_carry, o_carry_val, o_ins_set_mode, o_mode_dec,
                  o_ins_rstk_c, o_direction, o_ins_st_op, o_st_op, o_ins_p_inc, o_ins_p_set,
                  o_ins_lc, o_ins_jmp, o_jmp_call};

  always #5 i_clk = ~i_clk;
  always @(posedge i_clk) cyc++;

  function automatic void chk(string nm, logic [63:0] act, logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endfunction

  function automatic exp_t mk(flags_t f, logic [4:0] ins_len, logic [63:0] imm,
                              logic [4:0] imm_len, logic [19:0] addr, logic [19:0] jaddr);
    exp_t e;
    e.f = f; e.ins_len = ins_len; e.imm = imm; e.imm_len = imm_len;
    e.addr = addr; e.jaddr = jaddr; e.done_cyc = 0;
    return e;
  endfunction

  // Monitor: each rising edge of o_ins_decoded retires the oldest expected instruction.
  always @(negedge i_clk) begin
    if (o_ins_decoded && !prev_dec) begin
      if (sb.size() == 0) begin
        chk("unexpected_decode", 64'(o_ins_len), 64'hFFFF);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("flags", 64'(act_f), 64'(e.f));
        chk("ins_len", 64'(o_ins_len), 64'(e.ins_len));
        chk("imm", o_imm, e.imm);
        chk("imm_len", 64'(o_imm_len), 64'(e.imm_len));
        chk("ins_addr", 64'(o_ins_addr), 64'(e.addr));
        chk("jmp_addr", 64'(o_jmp_addr), 64'(e.jaddr));
        chk("done_cycle", 64'(cyc), 64'(e.done_cyc));
        chk("dec_error", 64'(o_dec_error), 64'h0);
      end
    end
    prev_dec = o_ins_decoded;
  end

  // Drive a nibble stream (nibble i at nibs[4i+3:4i]); optional stall after nibble index stall_after.
  task automatic issue(input int len, input logic [79:0] nibs, input logic [19:0] pc,
                       input int stall_after, input int stall_n, input exp_t e, input bit push);
    e.done_cyc = cyc + len + stall_n;
    if (push) sb.push_back(e);
    for (int i = 0; i < len; i++) begin
      i_en_dec = 1'b1; i_stalled = 1'b0;
      i_nibble = nibs[4*i +: 4];
      i_pc = pc + 20'(i);
      @(posedge i_clk); #1;
      if (i == stall_after) begin
        i_stalled = 1'b1;
        repeat (stall_n) begin @(posedge i_clk); #1; end
        i_stalled = 1'b0;
      end
    end
    i_en_dec = 1'b0;
    @(posedge i_clk); #1;
  endtask

  task automatic reset_and_check(input string tag);
    i_reset = 1'b1; i_en_dec = 1'b0;
    repeat (2) begin @(posedge i_clk); #1; end
    chk({tag, "_flags"}, 64'(act_f), 64'h0);
    chk({tag, "_decoded"}, 64'(o_ins_decoded), 64'h0);
    chk({tag, "_imm"}, o_imm, 64'h0);
    chk({tag, "_lens"}, 64'({o_ins_len, o_imm_len}), 64'h0);
    chk({tag, "_addrs"}, 64'({o_ins_addr, o_jmp_addr}), 64'h0);
    chk({tag, "_err_incpc"}, 64'({o_dec_error, o_inc_pc}), 64'h1);
    chk({tag, "_d4_err_incpc"}, 64'({d4_dec_error, d4_inc_pc}), 64'h1);
    i_reset = 1'b0;
    @(posedge i_clk); #1;
  endtask

  initial begin
    @(posedge i_clk); #1;
    reset_and_check("reset0");

    issue(2, 80'h30, 20'h00100, -1, 0,
          mk('{rtn:1'b1, set_carry:1'b1, carry_val:1'b1, default:'0}, 5'd2, 64'h0, 5'd0, 20'h00100, 20'h0), 1'b1);
    issue(2, 80'h00, 20'h00200, -1, 0,
          mk('{rtn:1'b1, set_xm:1'b1, default:'0}, 5'd2, 64'h0, 5'd0, 20'h00200, 20'h0), 1'b1);
    issue(2, 80'h20, 20'h00210, -1, 0,
          mk('{rtn:1'b1, set_carry:1'b1, default:'0}, 5'd2, 64'h0, 5'd0, 20'h00210, 20'h0), 1'b1);
    issue(2, 80'h40, 20'h00300, -1, 0,
          mk('{set_mode:1'b1, default:'0}, 5'd2, 64'h0, 5'd0, 20'h00300, 20'h0), 1'b1);
    issue(2, 80'h70, 20'h00400, -1, 0,
          mk('{rstk_c:1'b1, direction:1'b1, default:'0}, 5'd2, 64'h0, 5'd0, 20'h00400, 20'h0), 1'b1);
    issue(2, 80'h60, 20'h00402, -1, 0,
          mk('{rstk_c:1'b1, default:'0}, 5'd2, 64'h0, 5'd0, 20'h00402, 20'h0), 1'b1);
    issue(2, 80'hA0, 20'h00500, -1, 0,
          mk('{st_v:1'b1, st_op:2'd2, default:'0}, 5'd2, 64'h0, 5'd0, 20'h00500, 20'h0), 1'b1);
    issue(2, 80'hD0, 20'h00600, -1, 0,
          mk('{p_inc:1'b1, direction:1'b1, default:'0}, 5'd2, 64'h0, 5'd0, 20'h00600, 20'h0), 1'b1);
    issue(2, 80'hC0, 20'h00602, -1, 0,
          mk('{p_inc:1'b1, default:'0}, 5'd2, 64'h0, 5'd0, 20'h00602, 20'h0), 1'b1);
    issue(2, 80'h92, 20'h00700, -1, 0,
          mk('{p_set:1'b1, default:'0}, 5'd2, 64'h9, 5'd1, 20'h00700, 20'h0), 1'b1);
    // LC of 4 nibbles (stream 3,3,A,B,C,D) with a 2-cycle stall after the A nibble
    issue(6, 80'hDCBA33, 20'h00800, 2, 2,
          mk('{lc:1'b1, default:'0}, 5'd6, 64'hDCBA, 5'd4, 20'h00800, 20'h0), 1'b1);
    issue(3, 80'h503, 20'h00900, -1, 0,
          mk('{lc:1'b1, default:'0}, 5'd3, 64'h5, 5'd1, 20'h00900, 20'h0), 1'b1);

    // Partial LC interrupted by reset, then SETDEC must decode cleanly
    issue(3, 80'hA23, 20'h00A00, -1, 0, mk('0, 5'd0, 64'h0, 5'd0, 20'h0, 20'h0), 1'b0);
    reset_and_check("reset_mid");
    issue(2, 80'h50, 20'h00B00, -1, 0,
          mk('{set_mode:1'b1, mode_dec:1'b1, default:'0}, 5'd2, 64'h0, 5'd0, 20'h00B00, 20'h0), 1'b1);

`ifdef SATURN_DEC_JUMP_EN
    issue(4, 80'hFFE7, 20'h00010, -1, 0,
          mk('{jmp:1'b1, call:1'b1, default:'0}, 5'd4, 64'h0, 5'd0, 20'h00010, 20'h0000F), 1'b1);
    issue(4, 80'h0206, 20'h00020, -1, 0,
          mk('{jmp:1'b1, default:'0}, 5'd4, 64'h0, 5'd0, 20'h00020, 20'h00041), 1'b1);
`else
    issue(4, 80'hFFE7, 20'h00010, -1, 0, mk('0, 5'd0, 64'h0, 5'd0, 20'h0, 20'h0), 1'b0);
    chk("jmp_off_err", 64'({o_dec_error, o_inc_pc, o_ins_decoded}), 64'h4);
    reset_and_check("reset_jmp");
`endif

    // LC of 16 nibbles: fits the wide instance, overflows the 4-nibble instance
    issue(18, {8'h00, 64'hFEDCBA9876543210, 4'hF, 4'h3}, 20'h00C00, -1, 0,
          mk('{lc:1'b1, default:'0}, 5'd18, 64'hFEDCBA9876543210, 5'd16, 20'h00C00, 20'h0), 1'b1);
    chk("d4_overflow_err", 64'({d4_dec_error, d4_inc_pc}), 64'h2);
    chk("d4_halt_ignores", 64'({d4_ins_decoded, d4_ins_lc, d4_imm}), 64'h0);

    for (int i = 0; i < 20 && sb.size() != 0; i++) begin
      @(posedge i_clk); #1;
    end
    chk("scoreboard_drained", 64'(sb.size()), 64'h0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
